// File: rtl/qspi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : qspi_flash_responder
// Description : SPI/QSPI flash target emulator (mode 0). It oversamples
//               sck/cs_n/dq in the clk domain, decodes the read commands
//               (0x03, 0x0B, 0x6B) and the ID command (0x9F), and streams
//               bytes from a 1-cycle-latency synchronous memory back on dq.
// Ports       : clk, reset          - system clock, async active-high reset
//               sck, cs_n, dq_i     - pad-side inputs from the QSPI master
//               dq_o, dq_oe         - pad output values / output enables
//               mem_req, mem_addr   - one-cycle read strobe and byte address
//               mem_rdata           - read data, valid 1 clk after mem_req
//               busy                - transaction active (synchronized cs_n)
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_flash_responder #(
    parameter int          ADDR_W    = 24,
    parameter int          DUMMY_CYC = 8,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              cs_n,
    input  logic [3:0]        dq_i,
    output logic [3:0]        dq_o,
    output logic [3:0]        dq_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_cmd    = 3'd1;
    localparam logic [2:0] c_addr   = 3'd2;
    localparam logic [2:0] c_dummy  = 3'd3;
    localparam logic [2:0] c_data   = 3'd4;
    localparam logic [2:0] c_id     = 3'd5;
    localparam logic [2:0] c_ignore = 3'd6;

    localparam logic       c_has_dummy  = (DUMMY_CYC > 0);
    localparam logic [7:0] c_dummy_last = 8'(DUMMY_CYC - 1);

    // Synchronizers; stage 3 is the edge-detect reference
    logic              r_sck_s1, r_sck_s2, r_sck_s3;
    logic              r_cs_s1, r_cs_s2, r_cs_s3;
    logic [3:0]        r_dq_s1, r_dq_s2;

    logic [2:0]        r_state;
    logic [7:0]        r_cnt;
    logic [6:0]        r_cmd_sh;
    logic [22:0]       r_addr_sh;
    logic [23:0]       r_addr;
    logic [7:0]        r_hold;
    logic [7:0]        r_dshift;
    logic [23:0]       r_id_sh;
    logic              r_dummy;
    logic              r_quad;
    logic              r_cap;
    logic [3:0]        r_dq_o;
    logic [3:0]        r_dq_oe;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_busy;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_cs_fall;
    logic              w_mosi;
    logic [7:0]        w_cmd;
    logic [23:0]       w_addr_full;
    logic              w_unused;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_s3;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_s3;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
    assign w_mosi      = r_dq_s2[0];
    assign w_cmd       = {r_cmd_sh, w_mosi};
    assign w_addr_full = {r_addr_sh, w_mosi};
    // Only dq[0] carries inbound data for the supported commands
    assign w_unused    = ^r_dq_s2[3:1];

    assign dq_o     = r_dq_o;
    assign dq_oe    = r_dq_oe;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // cs_n synchronizer resets to the idle (deasserted) level so that
            // releasing reset never fabricates a falling edge
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_s3   <= 1'b0;
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_cs_s3    <= 1'b1;
            r_dq_s1    <= 4'h0;
            r_dq_s2    <= 4'h0;
            r_state    <= c_idle;
            r_cnt      <= 8'd0;
            r_cmd_sh   <= 7'd0;
            r_addr_sh  <= 23'd0;
            r_addr     <= 24'd0;
            r_hold     <= 8'd0;
            r_dshift   <= 8'd0;
            r_id_sh    <= 24'd0;
            r_dummy    <= 1'b0;
            r_quad     <= 1'b0;
            r_cap      <= 1'b0;
            r_dq_o     <= 4'h0;
            r_dq_oe    <= 4'h0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_sck_s1 <= sck;
            r_sck_s2 <= r_sck_s1;
            r_sck_s3 <= r_sck_s2;
            r_cs_s1  <= cs_n;
            r_cs_s2  <= r_cs_s1;
            r_cs_s3  <= r_cs_s2;
            r_dq_s1  <= dq_i;
            r_dq_s2  <= r_dq_s1;

            r_mem_req <= 1'b0;
            // Memory answers one clk after the strobe; r_cap marks that cycle
            r_cap     <= r_mem_req;
            if (r_cap && !r_cs_s2) begin
                r_hold <= mem_rdata;
                r_addr <= r_addr + 24'd1;
            end

            if (r_cs_s2) begin
                // Deselect overrides any sck edge seen in the same cycle
                r_state <= c_idle;
                r_busy  <= 1'b0;
                r_dq_oe <= 4'h0;
                r_dq_o  <= 4'h0;
                r_cnt   <= 8'd0;
                r_cap   <= 1'b0;
            end else if (w_cs_fall) begin
                r_state <= c_cmd;
                r_busy  <= 1'b1;
                r_cnt   <= 8'd0;
            end else begin
                case (r_state)
                    c_cmd: begin
                        if (w_sck_rise) begin
                            r_cmd_sh <= w_cmd[6:0];
                            if (r_cnt == 8'd7) begin
                                r_cnt   <= 8'd0;
                                r_dummy <= 1'b0;
                                r_quad  <= 1'b0;
                                case (w_cmd)
                                    8'h03: r_state <= c_addr;
                                    8'h0B: begin
                                        r_state <= c_addr;
                                        r_dummy <= 1'b1;
                                    end
                                    8'h6B: begin
                                        r_state <= c_addr;
                                        r_dummy <= 1'b1;
                                        r_quad  <= 1'b1;
                                    end
                                    8'h9F: begin
                                        r_state <= c_id;
                                        r_id_sh <= JEDEC_ID;
                                    end
                                    default: r_state <= c_ignore;
                                endcase
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    c_addr: begin
                        if (w_sck_rise) begin
                            r_addr_sh <= w_addr_full[22:0];
                            if (r_cnt == 8'd23) begin
                                r_cnt      <= 8'd0;
                                r_addr     <= w_addr_full;
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= w_addr_full[ADDR_W-1:0];
                                r_state    <= (r_dummy && c_has_dummy) ? c_dummy : c_data;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    c_dummy: begin
                        if (w_sck_rise) begin
                            if (r_cnt == c_dummy_last) begin
                                r_cnt   <= 8'd0;
                                r_state <= c_data;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    c_data: begin
                        if (w_sck_fall) begin
                            if (r_cnt == 8'd0) begin
                                // Byte boundary: load from holding register and
                                // prefetch the next address in the same cycle
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= r_addr[ADDR_W-1:0];
                                r_cnt      <= 8'd1;
                                if (r_quad) begin
                                    r_dq_oe  <= 4'hF;
                                    r_dq_o   <= r_hold[7:4];
                                    r_dshift <= {r_hold[3:0], 4'h0};
                                end else begin
                                    r_dq_oe  <= 4'b0010;
                                    r_dq_o   <= {2'b00, r_hold[7], 1'b0};
                                    r_dshift <= {r_hold[6:0], 1'b0};
                                end
                            end else if (r_quad) begin
                                r_dq_o   <= r_dshift[7:4];
                                r_dshift <= {r_dshift[3:0], 4'h0};
                                r_cnt    <= 8'd0;
                            end else begin
                                r_dq_o   <= {2'b00, r_dshift[7], 1'b0};
                                r_dshift <= {r_dshift[6:0], 1'b0};
                                r_cnt    <= (r_cnt == 8'd7) ? 8'd0 : r_cnt + 8'd1;
                            end
                        end
                    end
                    c_id: begin
                        if (w_sck_fall) begin
                            // Rotate so the ID repeats from bit 23 after 24 bits
                            r_dq_oe <= 4'b0010;
                            r_dq_o  <= {2'b00, r_id_sh[23], 1'b0};
                            r_id_sh <= {r_id_sh[22:0], r_id_sh[23]};
                        end
                    end
                    default: ; // c_idle, c_ignore: wait for deselect
                endcase
            end
        end
    end

endmodule
`default_nettype wire
